video_line_trig_ctrl: RTL



---
 rtl/vtrig_pkg.sv | 38 +++
 rtl/vtrig_edge_sync.sv | 32 +++
 rtl/video_line_trig_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/vtrig_pkg.sv
// Shared types and constants for the video line-trigger controller.
// Holds the FSM state encoding, field_sel codes, video mode codes, the
// default per-field line maxima and the field qualification helper.
package vtrig_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'b00,
        ST_WAIT_FIELD = 2'b01,
        ST_COUNT      = 2'b10,
        ST_HOLDOFF    = 2'b11
    } vtrig_state_t;

    localparam logic [1:0] FSEL_ANY  = 2'b00;
    localparam logic [1:0] FSEL_ODD  = 2'b01;
    localparam logic [1:0] FSEL_EVEN = 2'b10;
    localparam logic [1:0] FSEL_RSVD = 2'b11;

    localparam logic MODE_NTSC = 1'b0;
    localparam logic MODE_PAL  = 1'b1;

    localparam int DEF_NTSC_FIELD_LINES = 263;
    localparam int DEF_PAL_FIELD_LINES  = 313;

    // True when a field-start pulse of the given parity satisfies fsel.
    function automatic logic field_match(input logic [1:0] fsel,
                                         input logic       odd_pulse,
                                         input logic       even_pulse);
        logic hit;
        case (fsel)
            FSEL_ANY:  hit = odd_pulse | even_pulse;
            FSEL_ODD:  hit = odd_pulse;
            FSEL_EVEN: hit = even_pulse;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/vtrig_edge_sync.sv
// Brings the asynchronous composite hsync into the clk_in domain through a
// SYNC_STAGES flop chain, then flags the high-to-low transition with a
// one-cycle pulse using one extra delay flop.
module vtrig_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic sig_in,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   dly_r;
    logic                   sync_s;

    assign sync_s = sync_r[SYNC_STAGES-1];

    // Metastability chain followed by the edge-detect delay flop.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {SYNC_STAGES{1'b0}};
            dly_r  <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], sig_in};
            dly_r  <= sync_s;
        end
    end

    assign fall = dly_r & ~sync_s;

endmodule

// File: rtl/video_line_trig_ctrl.sv
// Video line-trigger controller: arms on request, waits for a qualifying
// field start, counts hsync lines and fires a one-cycle trigger on the
// selected line, then applies a field holdoff before re-arming or idling.
// Optional build macro VTRIG_MISS_CNT_EN enables the missed-field counter;
// without it miss_cnt is tied to zero.
module video_line_trig_ctrl
    import vtrig_pkg::*;
#(
    parameter int SYNC_STAGES      = 2,
    parameter int LINE_W           = 10,
    parameter int NTSC_FIELD_LINES = DEF_NTSC_FIELD_LINES,
    parameter int PAL_FIELD_LINES  = DEF_PAL_FIELD_LINES
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              hs_in,
    input  logic              odd_field_tri,
    input  logic              even_field_tri,
    input  logic              video_mode,
    input  logic              arm,
    input  logic              abort,
    input  logic              auto_rearm,
    input  logic [1:0]        field_sel,
    input  logic [LINE_W-1:0] line_sel,
    input  logic [3:0]        holdoff_fields,
    output logic              trig_out,
    output logic              armed,
    output logic              busy,
    output logic              cfg_err,
    output logic [LINE_W-1:0] line_cnt,
    output logic [7:0]        miss_cnt
);

    localparam logic [LINE_W-1:0] LINE_ZERO = {LINE_W{1'b0}};
    localparam logic [LINE_W-1:0] LINE_ONE  = {{(LINE_W-1){1'b0}}, 1'b1};
    localparam logic [LINE_W-1:0] LINE_SAT  = {LINE_W{1'b1}};
    localparam logic [LINE_W-1:0] NTSC_MAX  = LINE_W'(NTSC_FIELD_LINES);
    localparam logic [LINE_W-1:0] PAL_MAX   = LINE_W'(PAL_FIELD_LINES);

    // Config legality: real field selection and a 1-based line inside the field.
    function automatic logic cfg_legal(input logic              mode,
                                       input logic [1:0]        fsel,
                                       input logic [LINE_W-1:0] line);
        logic [LINE_W-1:0] lmax;
        lmax = (mode == MODE_PAL) ? PAL_MAX : NTSC_MAX;
        return (fsel != FSEL_RSVD) && (line != LINE_ZERO) && (line <= lmax);
    endfunction

    vtrig_state_t      state_r;
    vtrig_state_t      state_nx_s;
    vtrig_state_t      exit_state_s;
    vtrig_state_t      fire_state_s;
    logic [3:0]        hcnt_r;
    logic [3:0]        hcnt_nx_s;
    logic              hs_fall_s;
    logic              field_any_s;
    logic              field_hit_s;
    logic [LINE_W-1:0] line_cnt_nx_s;
    logic              arm_cfg_ok_s;
    logic              shadow_ok_s;
    logic              line_one_s;
    logic              fire_s;
    logic              accept_s;
    logic              reject_s;

    logic              sh_mode_r;
    logic [1:0]        sh_fsel_r;
    logic [LINE_W-1:0] sh_line_r;
    logic [3:0]        sh_hold_r;
    logic              sh_auto_r;

    vtrig_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_hs_sync (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .sig_in (hs_in),
        .fall   (hs_fall_s)
    );

    assign field_any_s  = odd_field_tri | even_field_tri;
    assign field_hit_s  = field_match(sh_fsel_r, odd_field_tri, even_field_tri);
    // At arm time the live inputs are exactly what gets latched, so they are judged directly.
    assign arm_cfg_ok_s = cfg_legal(video_mode, field_sel, line_sel);
    // Re-check of the latched copy guards against a corrupted shadow register.
    assign shadow_ok_s  = cfg_legal(sh_mode_r, sh_fsel_r, sh_line_r);
    assign line_one_s   = (sh_line_r == LINE_ONE);
    assign exit_state_s = sh_auto_r ? ST_WAIT_FIELD : ST_IDLE;
    assign fire_state_s = (sh_hold_r == 4'd0) ? exit_state_s : ST_HOLDOFF;

    // Line counter next value: field start forces line 1, hsync fall advances with saturation.
    always_comb begin
        line_cnt_nx_s = line_cnt;
        if (field_any_s) begin
            line_cnt_nx_s = LINE_ONE;
        end else if (hs_fall_s && (line_cnt != LINE_SAT)) begin
            line_cnt_nx_s = line_cnt + LINE_ONE;
        end else begin
            line_cnt_nx_s = line_cnt;
        end
    end

    // Next-state, holdoff reload and fire decode; abort overrides everything.
    always_comb begin
        state_nx_s = state_r;
        hcnt_nx_s  = hcnt_r;
        fire_s     = 1'b0;
        accept_s   = 1'b0;
        reject_s   = 1'b0;
        if (abort) begin
            state_nx_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (arm && arm_cfg_ok_s) begin
                        accept_s   = 1'b1;
                        state_nx_s = ST_WAIT_FIELD;
                    end else if (arm) begin
                        reject_s   = 1'b1;
                        state_nx_s = ST_IDLE;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_WAIT_FIELD: begin
                    if (!shadow_ok_s) begin
                        state_nx_s = ST_IDLE;
                    end else if (field_any_s && field_hit_s) begin
                        fire_s     = line_one_s;
                        state_nx_s = line_one_s ? fire_state_s : ST_COUNT;
                        hcnt_nx_s  = sh_hold_r;
                    end else begin
                        state_nx_s = ST_WAIT_FIELD;
                    end
                end
                ST_COUNT: begin
                    if (!shadow_ok_s) begin
                        state_nx_s = ST_IDLE;
                    end else if (field_any_s && field_hit_s) begin
                        // Missed the target line; this field qualifies, so count it afresh.
                        fire_s     = line_one_s;
                        state_nx_s = line_one_s ? fire_state_s : ST_COUNT;
                        hcnt_nx_s  = sh_hold_r;
                    end else if (field_any_s) begin
                        state_nx_s = ST_WAIT_FIELD;
                    end else if (hs_fall_s && (line_cnt_nx_s == sh_line_r)) begin
                        fire_s     = 1'b1;
                        state_nx_s = fire_state_s;
                        hcnt_nx_s  = sh_hold_r;
                    end else begin
                        state_nx_s = ST_COUNT;
                    end
                end
                ST_HOLDOFF: begin
                    if (field_any_s && (hcnt_r <= 4'd1)) begin
                        // The pulse that empties holdoff is consumed here, not used to qualify.
                        hcnt_nx_s  = 4'd0;
                        state_nx_s = exit_state_s;
                    end else if (field_any_s) begin
                        hcnt_nx_s  = hcnt_r - 4'd1;
                        state_nx_s = ST_HOLDOFF;
                    end else begin
                        state_nx_s = ST_HOLDOFF;
                    end
                end
                default: begin
                    state_nx_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, holdoff counter and registered status outputs.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            hcnt_r   <= 4'd0;
            trig_out <= 1'b0;
            armed    <= 1'b0;
            busy     <= 1'b0;
            line_cnt <= LINE_ZERO;
        end else begin
            state_r  <= state_nx_s;
            hcnt_r   <= hcnt_nx_s;
            trig_out <= fire_s;
            armed    <= (state_nx_s == ST_WAIT_FIELD) || (state_nx_s == ST_COUNT);
            busy     <= (state_nx_s != ST_IDLE);
            line_cnt <= line_cnt_nx_s;
        end
    end

    // Shadow config capture on any arm seen in IDLE, plus sticky config error.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sh_mode_r <= MODE_NTSC;
            sh_fsel_r <= FSEL_ANY;
            sh_line_r <= LINE_ZERO;
            sh_hold_r <= 4'd0;
            sh_auto_r <= 1'b0;
            cfg_err   <= 1'b0;
        end else if (accept_s || reject_s) begin
            sh_mode_r <= video_mode;
            sh_fsel_r <= field_sel;
            sh_line_r <= line_sel;
            sh_hold_r <= holdoff_fields;
            sh_auto_r <= auto_rearm;
            cfg_err   <= reject_s;
        end else begin
            cfg_err   <= cfg_err;
        end
    end

`ifdef VTRIG_MISS_CNT_EN
    logic [7:0] miss_cnt_r;
    logic       miss_inc_s;

    // A field start while still counting means the target line never came.
    assign miss_inc_s = (state_r == ST_COUNT) && field_any_s && !abort;

    // Saturating missed-field counter, cleared by an accepted arm.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            miss_cnt_r <= 8'd0;
        end else if (accept_s) begin
            miss_cnt_r <= 8'd0;
        end else if (miss_inc_s && (miss_cnt_r != 8'hFF)) begin
            miss_cnt_r <= miss_cnt_r + 8'd1;
        end else begin
            miss_cnt_r <= miss_cnt_r;
        end
    end

    assign miss_cnt = miss_cnt_r;
`else
    assign miss_cnt = 8'd0;
`endif

endmodule
